// File: rtl/axi_mem_responder_381.sv
// axi_mem_responder_381
//   AXI4 memory responder backed by on-chip RAM. It serves the MSM kernel's
//   AXI master port in place of HBM/DDR. Read and write channels run
//   independent FSMs. Only INCR bursts at full bus width are supported.
//   Memory contents survive reset.
// Ports
//   ap_clk, ap_rst                  clock, synchronous active-high reset
//   s_AR* / s_R*                    read address and read data channels
//   s_AW* / s_W* / s_B*             write address, write data and write response channels
// Notes
//   word index = ADDR[log2(BYTES) +: C_MEM_DEPTH_LOG2]. Low and high address bits are
//   ignored, so unaligned addresses act as aligned and high addresses alias.
//   Burst indices wrap modulo the memory depth.
module axi_mem_responder_381 #(
  parameter int C_AXI_M_ADDR_W   = 64,
  parameter int C_AXI_M_DATA_W   = 512,
  parameter int C_AXI_M_ID_W     = 1,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          s_ARVALID,
  output logic                          s_ARREADY,
  input  logic [C_AXI_M_ADDR_W-1:0]     s_ARADDR,
  input  logic [C_AXI_M_ID_W-1:0]       s_ARID,
  input  logic [7:0]                    s_ARLEN,
  input  logic [2:0]                    s_ARSIZE,
  output logic                          s_RVALID,
  input  logic                          s_RREADY,
  output logic [C_AXI_M_DATA_W-1:0]     s_RDATA,
  output logic                          s_RLAST,
  output logic [C_AXI_M_ID_W-1:0]       s_RID,
  output logic [1:0]                    s_RRESP,
  input  logic                          s_AWVALID,
  output logic                          s_AWREADY,
  input  logic [C_AXI_M_ADDR_W-1:0]     s_AWADDR,
  input  logic [C_AXI_M_ID_W-1:0]       s_AWID,
  input  logic [7:0]                    s_AWLEN,
  input  logic [2:0]                    s_AWSIZE,
  input  logic                          s_WVALID,
  output logic                          s_WREADY,
  input  logic [C_AXI_M_DATA_W-1:0]     s_WDATA,
  input  logic [C_AXI_M_DATA_W/8-1:0]   s_WSTRB,
  input  logic                          s_WLAST,
  output logic                          s_BVALID,
  input  logic                          s_BREADY,
  output logic [1:0]                    s_BRESP,
  output logic [C_AXI_M_ID_W-1:0]       s_BID
);

  localparam int BYTES = C_AXI_M_DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = C_MEM_DEPTH_LOG2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_SEND = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

  logic [C_AXI_M_DATA_W-1:0] mem_q [DEPTH];
  logic [C_AXI_M_DATA_W-1:0] mem_rdata_q;

  // Read channel state
  r_state_e                  r_state_q, r_state_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [C_AXI_M_DATA_W-1:0] rdata_q, rdata_d;
  logic [C_AXI_M_ID_W-1:0]   rid_q, rid_d, r_id_q;
  logic [IDX_W-1:0]          r_idx_q, ar_idx_s, rd_idx_s;
  logic [7:0]                r_len_q, r_cnt_q;
  logic                      ar_hs_s, r_hs_s, rd_en_s;

  // Write channel state
  w_state_e                  w_state_q, w_state_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [C_AXI_M_ID_W-1:0]   bid_q, bid_d, w_id_q;
  logic [IDX_W-1:0]          w_idx_q, aw_idx_s;
  logic [7:0]                w_len_q, w_cnt_q;
  logic                      aw_hs_s, w_hs_s, b_hs_s, w_end_s, w_err_s, w_cnt_at_len_s;

  // Address bits outside the word index and the size fields carry no information here.
  logic unused_s;
  assign unused_s = ^{s_ARSIZE, s_AWSIZE,
                      s_ARADDR[OFF_W-1:0], s_ARADDR[C_AXI_M_ADDR_W-1:OFF_W+IDX_W],
                      s_AWADDR[OFF_W-1:0], s_AWADDR[C_AXI_M_ADDR_W-1:OFF_W+IDX_W]};

  assign s_ARREADY = arready_q;
  assign s_RVALID  = rvalid_q;
  assign s_RDATA   = rdata_q;
  assign s_RLAST   = rlast_q;
  assign s_RID     = rid_q;
  assign s_RRESP   = 2'b00;
  assign s_AWREADY = awready_q;
  assign s_WREADY  = wready_q;
  assign s_BVALID  = bvalid_q;
  assign s_BRESP   = bresp_q;
  assign s_BID     = bid_q;

  assign ar_idx_s = s_ARADDR[OFF_W +: IDX_W];
  assign aw_idx_s = s_AWADDR[OFF_W +: IDX_W];
  assign ar_hs_s  = arready_q & s_ARVALID;
  assign r_hs_s   = rvalid_q & s_RREADY;
  assign aw_hs_s  = awready_q & s_AWVALID;
  assign w_hs_s   = wready_q & s_WVALID;
  assign b_hs_s   = bvalid_q & s_BREADY;

  // The RAM read is issued in the handshake cycle itself, so data is ready for the FETCH state.
  assign rd_en_s  = ar_hs_s | (r_hs_s & ~rlast_q);
  assign rd_idx_s = ar_hs_s ? ar_idx_s : (r_idx_q + IDX_W'(1'b1));

  // A burst closes on WLAST or on the beat count reaching len; any disagreement is an error.
  assign w_cnt_at_len_s = (w_cnt_q == w_len_q);
  assign w_end_s        = s_WLAST | w_cnt_at_len_s;
  assign w_err_s        = s_WLAST ^ w_cnt_at_len_s;

  // RAM synchronous read port; returns old data on a same-cycle write
  always_ff @(posedge ap_clk) begin
    if (rd_en_s) mem_rdata_q <= mem_q[rd_idx_s];
  end

  // RAM byte-enable write port; contents are not touched by reset
  always_ff @(posedge ap_clk) begin
    if (w_hs_s && !ap_rst) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_WSTRB[b]) mem_q[w_idx_q][8*b +: 8] <= s_WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next-state logic
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_s) r_state_d = R_FETCH; else r_state_d = R_IDLE;
      R_FETCH: r_state_d = R_SEND;
      R_SEND:  if (r_hs_s) r_state_d = rlast_q ? R_IDLE : R_FETCH; else r_state_d = R_SEND;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel output next values; outputs are registered from these
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_SEND);
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    if (r_state_q == R_FETCH) begin
      rdata_d = mem_rdata_q;
      rlast_d = (r_cnt_q == r_len_q);
      rid_d   = r_id_q;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read channel output registers and burst bookkeeping
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      if (ar_hs_s) begin
        r_idx_q <= ar_idx_s;
        r_len_q <= s_ARLEN;
        r_id_q  <= s_ARID;
        r_cnt_q <= 8'd0;
      end else if (r_hs_s && !rlast_q) begin
        r_idx_q <= r_idx_q + IDX_W'(1'b1);
        r_cnt_q <= r_cnt_q + 8'd1;
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next-state logic
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
      W_DATA:  if (w_hs_s && w_end_s) w_state_d = W_RESP; else w_state_d = W_DATA;
      W_RESP:  if (b_hs_s) w_state_d = W_IDLE; else w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel output next values; outputs are registered from these
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    if ((w_state_q == W_DATA) && w_hs_s && w_end_s) begin
      bresp_d = w_err_s ? 2'b10 : 2'b00;
      bid_d   = w_id_q;
    end else begin
      bresp_d = bresp_q;
    end
  end

  // Write channel output registers and burst bookkeeping
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      if (aw_hs_s) begin
        w_idx_q <= aw_idx_s;
        w_len_q <= s_AWLEN;
        w_id_q  <= s_AWID;
        w_cnt_q <= 8'd0;
      end else if (w_hs_s) begin
        w_idx_q <= w_idx_q + IDX_W'(1'b1);
        w_cnt_q <= w_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder_381.sv
// Directed bench for axi_mem_responder_381: writes/reads with hand-chosen data,
// strobe merge, index wrap, WLAST errors, RREADY back-pressure, concurrency, reset.
module tb_axi_mem_responder_381;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int IW    = 1;
  localparam int DEPTH = 1024;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          s_ARVALID, s_ARREADY;
  logic [AW-1:0] s_ARADDR;
  logic [IW-1:0] s_ARID;
  logic [7:0]    s_ARLEN;
  logic [2:0]    s_ARSIZE;
  logic          s_RVALID, s_RREADY;
  logic [DW-1:0] s_RDATA;
  logic          s_RLAST;
  logic [IW-1:0] s_RID;
  logic [1:0]    s_RRESP;
  logic          s_AWVALID, s_AWREADY;
  logic [AW-1:0] s_AWADDR;
  logic [IW-1:0] s_AWID;
  logic [7:0]    s_AWLEN;
  logic [2:0]    s_AWSIZE;
  logic          s_WVALID, s_WREADY;
  logic [DW-1:0] s_WDATA;
  logic [DW/8-1:0] s_WSTRB;
  logic          s_WLAST;
  logic          s_BVALID, s_BREADY;
  logic [1:0]    s_BRESP;
  logic [IW-1:0] s_BID;

  axi_mem_responder_381 dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARID(s_ARID),
    .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST),
    .s_RID(s_RID), .s_RRESP(s_RRESP),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWID(s_AWID),
    .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
    .s_WLAST(s_WLAST),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP), .s_BID(s_BID)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mdl  [0:DEPTH-1];
  logic [DW-1:0] wbuf [0:15];
  logic [DW-1:0] rbuf [0:255];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] seed);
    return {16{seed}};
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic id,
                          input int nbeats, input int wlast_at, input logic [DW/8-1:0] strb,
                          output logic [1:0] resp, output logic bid, output int bwait);
    int t;
    int idx;
    s_AWVALID = 1'b1; s_AWADDR = addr; s_AWLEN = len; s_AWID = id; s_AWSIZE = 3'd6;
    t = 0;
    while (!s_AWREADY && t < 50) begin tick(); t++; end
    if (t >= 50) check_eq("aw_timeout", s_AWREADY, 1);
    tick();
    s_AWVALID = 1'b0;
    idx = int'(addr[6 +: 10]);
    for (int i = 0; i < nbeats; i++) begin
      s_WVALID = 1'b1; s_WDATA = wbuf[i]; s_WSTRB = strb; s_WLAST = (i == wlast_at);
      t = 0;
      while (!s_WREADY && t < 50) begin tick(); t++; end
      if (t >= 50) check_eq("w_timeout", s_WREADY, 1);
      tick();
      for (int b = 0; b < DW/8; b++) if (strb[b]) mdl[idx][8*b +: 8] = wbuf[i][8*b +: 8];
      idx = (idx + 1) % DEPTH;
    end
    s_WVALID = 1'b0; s_WLAST = 1'b0;
    bwait = 0;
    while (!s_BVALID && bwait < 50) begin tick(); bwait++; end
    resp = s_BRESP; bid = s_BID;
    s_BREADY = 1'b1;
    tick();
    s_BREADY = 1'b0;
    check_eq("bvalid_drop", s_BVALID, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic id,
                         input int stall_at, output int lat);
    int t;
    int idx;
    logic [DW-1:0] hd;
    logic hl;
    lat = -1;
    s_ARVALID = 1'b1; s_ARADDR = addr; s_ARLEN = len; s_ARID = id; s_ARSIZE = 3'd6;
    t = 0;
    while (!s_ARREADY && t < 50) begin tick(); t++; end
    if (t >= 50) check_eq("ar_timeout", s_ARREADY, 1);
    tick();
    s_ARVALID = 1'b0;
    idx = int'(addr[6 +: 10]);
    for (int i = 0; i <= int'(len); i++) begin
      s_RREADY = (i != stall_at);
      t = 0;
      while (!s_RVALID && t < 50) begin tick(); t++; end
      if (i == 0) lat = t;
      if (t >= 50) check_eq("r_timeout", s_RVALID, 1);
      rbuf[i] = s_RDATA;
      check_eq($sformatf("rdata[%0d]", i), s_RDATA, mdl[idx]);
      check_eq($sformatf("rlast[%0d]", i), s_RLAST, (i == int'(len)));
      check_eq("rid", s_RID, id);
      check_eq("rresp", s_RRESP, 2'b00);
      if (i == stall_at) begin
        hd = s_RDATA; hl = s_RLAST;
        repeat (5) begin
          tick();
          check_eq("stall_rvalid", s_RVALID, 1);
          check_eq("stall_rdata", s_RDATA, hd);
          check_eq("stall_rlast", s_RLAST, hl);
        end
        s_RREADY = 1'b1;
      end
      tick();
      idx = (idx + 1) % DEPTH;
    end
    s_RREADY = 1'b0;
    check_eq("rvalid_drop", s_RVALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp, resp2;
    logic bid, bid2;
    int bw, bw2, lat, lat2, t;
    logic [DW/8-1:0] all_s;
    all_s = '1;

    ap_rst = 1'b1;
    s_ARVALID = 1'b0; s_ARADDR = '0; s_ARID = '0; s_ARLEN = 8'd0; s_ARSIZE = 3'd0; s_RREADY = 1'b0;
    s_AWVALID = 1'b0; s_AWADDR = '0; s_AWID = '0; s_AWLEN = 8'd0; s_AWSIZE = 3'd0;
    s_WVALID = 1'b0; s_WDATA = '0; s_WSTRB = '0; s_WLAST = 1'b0; s_BREADY = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_arready", s_ARREADY, 0);
    check_eq("rst_awready", s_AWREADY, 0);
    check_eq("rst_rvalid",  s_RVALID, 0);
    check_eq("rst_wready",  s_WREADY, 0);
    check_eq("rst_bvalid",  s_BVALID, 0);
    check_eq("rst_rdata",   s_RDATA, 0);
    ap_rst = 1'b0;
    tick();
    check_eq("idle_arready", s_ARREADY, 1);
    check_eq("idle_awready", s_AWREADY, 1);
    check_eq("idle_wready",  s_WREADY, 0);

    // 1: 4-beat write at 0x40 and readback
    for (int i = 0; i < 4; i++) wbuf[i] = pat(32'h0000_1000 + 32'(i));
    do_write(64'h40, 8'd3, 1'b0, 4, 3, all_s, resp, bid, bw);
    check_eq("t1_bwait", 32'(bw), 0);
    check_eq("t1_bresp", resp, 2'b00);
    check_eq("t1_bid", bid, 0);
    do_read(64'h40, 8'd3, 1'b0, -1, lat);
    check_eq("t1_ar_to_rvalid", 32'(lat), 1);
    check_eq("t1_beat3", rbuf[3], pat(32'h0000_1003));

    // 2: strobe merge
    wbuf[0] = {64{8'hAA}};
    do_write(64'h200, 8'd0, 1'b1, 1, 0, all_s, resp, bid, bw);
    check_eq("t2_bresp", resp, 2'b00);
    check_eq("t2_bid", bid, 1);
    wbuf[0] = {64{8'h55}};
    do_write(64'h200, 8'd0, 1'b0, 1, 0, 64'h0F, resp, bid, bw);
    do_read(64'h200, 8'd0, 1'b1, -1, lat);
    check_eq("t2_merge", rbuf[0], {{60{8'hAA}}, {4{8'h55}}});

    // 3: wrap from index 1022
    for (int i = 0; i < 4; i++) wbuf[i] = pat(32'h0000_3000 + 32'(i));
    do_write(64'hFF80, 8'd3, 1'b1, 4, 3, all_s, resp, bid, bw);
    check_eq("t3_bresp", resp, 2'b00);
    do_read(64'h0, 8'd0, 1'b0, -1, lat);
    check_eq("t3_idx0", rbuf[0], pat(32'h0000_3002));
    do_read(64'hFFC0, 8'd1, 1'b0, -1, lat);
    check_eq("t3_idx1023", rbuf[0], pat(32'h0000_3001));
    check_eq("t3_wrap0", rbuf[1], pat(32'h0000_3002));
    do_read(64'hDEAD_0000_0001_0047, 8'd0, 1'b0, -1, lat);
    check_eq("t3_alias", rbuf[0], pat(32'h0000_3003));

    // 4: early and missing WLAST
    for (int i = 0; i < 4; i++) wbuf[i] = pat(32'h0000_4000 + 32'(i));
    do_write(64'h400, 8'd3, 1'b0, 4, 3, all_s, resp, bid, bw);
    for (int i = 0; i < 4; i++) wbuf[i] = pat(32'h0000_4100 + 32'(i));
    do_write(64'h400, 8'd3, 1'b1, 2, 1, all_s, resp, bid, bw);
    check_eq("t4_early_bresp", resp, 2'b10);
    check_eq("t4_early_bid", bid, 1);
    check_eq("t4_wready_idle", s_WREADY, 0);
    do_read(64'h400, 8'd3, 1'b0, -1, lat);
    check_eq("t4_w0", rbuf[0], pat(32'h0000_4100));
    check_eq("t4_w1", rbuf[1], pat(32'h0000_4101));
    check_eq("t4_w2_kept", rbuf[2], pat(32'h0000_4002));
    do_write(64'h600, 8'd1, 1'b0, 2, -1, all_s, resp, bid, bw);
    check_eq("t4_missing_bresp", resp, 2'b10);

    // 5: back-pressure, then concurrent AW/AR
    for (int i = 0; i < 8; i++) wbuf[i] = pat(32'h0000_5000 + 32'(i));
    do_write(64'h800, 8'd7, 1'b0, 8, 7, all_s, resp, bid, bw);
    do_read(64'h800, 8'd7, 1'b0, 3, lat);
    for (int i = 0; i < 4; i++) wbuf[i] = pat(32'h0000_5100 + 32'(i));
    fork
      do_write(64'hC00, 8'd3, 1'b1, 4, 3, all_s, resp2, bid2, bw2);
      do_read(64'h800, 8'd7, 1'b1, -1, lat2);
    join
    check_eq("t5_conc_bresp", resp2, 2'b00);
    check_eq("t5_conc_bid", bid2, 1);
    do_read(64'hC00, 8'd3, 1'b0, -1, lat);
    check_eq("t5_conc_w3", rbuf[3], pat(32'h0000_5103));

    // 6: reset during beat 2 of an 8-beat read
    s_ARVALID = 1'b1; s_ARADDR = 64'h800; s_ARLEN = 8'd7; s_ARID = 1'b0;
    t = 0;
    while (!s_ARREADY && t < 50) begin tick(); t++; end
    tick();
    s_ARVALID = 1'b0;
    s_RREADY = 1'b1;
    t = 0;
    while (!s_RVALID && t < 50) begin tick(); t++; end
    tick();
    s_RREADY = 1'b0;
    t = 0;
    while (!s_RVALID && t < 50) begin tick(); t++; end
    check_eq("t6_beat2_valid", s_RVALID, 1);
    check_eq("t6_beat2_data", s_RDATA, pat(32'h0000_5001));
    ap_rst = 1'b1;
    tick();
    check_eq("t6_rvalid_rst", s_RVALID, 0);
    check_eq("t6_arready_rst", s_ARREADY, 0);
    check_eq("t6_rlast_rst", s_RLAST, 0);
    ap_rst = 1'b0;
    s_RREADY = 1'b1;
    tick();
    check_eq("t6_arready_rel", s_ARREADY, 1);
    check_eq("t6_rvalid_rel", s_RVALID, 0);
    tick();
    check_eq("t6_no_stray_beat", s_RVALID, 0);
    s_RREADY = 1'b0;
    do_read(64'h800, 8'd7, 1'b0, -1, lat);
    check_eq("t6_intact7", rbuf[7], pat(32'h0000_5007));
    do_read(64'h80, 8'd2, 1'b1, -1, lat);
    check_eq("t6_intact_t1", rbuf[0], pat(32'h0000_1001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
